// File: rtl/dmem_responder_if.sv
// Shared types and the requester/data-memory interface for dmem_responder.
// XLEN defaults to 32 when not supplied by the build.
`ifndef XLEN
`define XLEN 32
`endif

package dmem_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic {
    FU_LOAD  = 1'b0,
    FU_STORE = 1'b1
  } FU_MEM_CMD;

  typedef struct packed {
    FU_MEM_CMD         command;
    logic [`XLEN-1:0]  addr;
    logic [`XLEN-1:0]  data;
    MEM_SIZE           size;
  } FU_MEM_PACKET;
endpackage

interface dmem_if
  import dmem_pkg::*;
#(
  parameter int N_PORTS = 2
);
  logic         [N_PORTS-1:0]            mem_req;
  FU_MEM_PACKET [N_PORTS-1:0]            fu_mem_packet;
  logic         [N_PORTS-1:0]            mem_ack;
  logic         [N_PORTS-1:0]            mem_err;
  logic         [N_PORTS-1:0][`XLEN-1:0] Dmem2proc_data;
  BUS_COMMAND                            proc2Dmem_command;
  logic         [`XLEN-1:0]              proc2Dmem_addr;
  logic         [63:0]                   proc2Dmem_data;
  MEM_SIZE                               proc2Dmem_size;
  logic         [3:0]                    Mem2proc_response;
  logic         [63:0]                   Mem2proc_data;
  logic         [3:0]                    Mem2proc_tag;

  modport slave (
    input  mem_req, fu_mem_packet, Mem2proc_response, Mem2proc_data, Mem2proc_tag,
    output mem_ack, mem_err, Dmem2proc_data,
           proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
  );

  modport master (
    output mem_req, fu_mem_packet, Mem2proc_response, Mem2proc_data, Mem2proc_tag,
    input  mem_ack, mem_err, Dmem2proc_data,
           proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
  );
endinterface

// File: rtl/dmem_responder.sv
// Arbitrates FU load/store requests onto the tagged data-memory bus and acks each one.
// DMEM_RR_ARB_EN selects round-robin arbitration; otherwise lowest port index wins.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N_PORTS = 2
) (
  input logic  clock,
  input logic  reset,
  dmem_if.slave bus
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;

  state_t                          state_q, state_d;
  logic [PW-1:0]                   grant_q, grant_d;
  FU_MEM_CMD                       cmd_q, cmd_d;
  logic [2:0]                      off_q, off_d;
  logic                            err_q, err_d;
  logic [3:0]                      tag_q, tag_d;
  logic [`XLEN-1:0]                baddr_q, baddr_d;
  logic [63:0]                     bdata_q, bdata_d;
  MEM_SIZE                         bsize_q, bsize_d;
  logic [N_PORTS-1:0][`XLEN-1:0]   rdata_q, rdata_d;
`ifdef DMEM_RR_ARB_EN
  logic [PW-1:0]                   rr_q, rr_d;
`endif

  logic [PW-1:0]                   sel;
  FU_MEM_PACKET                    req_pkt;
  logic [N_PORTS-1:0]              ack_vec;
  BUS_COMMAND                      bus_cmd;

  function automatic logic misaligned(input MEM_SIZE s, input logic [2:0] a);
    case (s)
      HALF:    return a[0];
      WORD:    return |a[1:0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] store_lane(input logic [`XLEN-1:0] d, input logic [2:0] off);
    logic [63:0] ext;
    ext = 64'(d);
    return ext << {off, 3'b000};
  endfunction

  function automatic logic [`XLEN-1:0] load_extract(input logic [63:0] blk, input logic [2:0] off);
    logic [63:0] sh;
    sh = blk >> {off, 3'b000};
    return sh[`XLEN-1:0];
  endfunction

  // Arbitration: only consulted in IDLE, so the grant stays locked until ACK.
  always_comb begin
    sel = grant_q;
`ifdef DMEM_RR_ARB_EN
    begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = (int'(rr_q) + k) % N_PORTS;
        if (!found && bus.mem_req[idx]) begin
          sel   = PW'(idx);
          found = 1'b1;
        end
      end
    end
`else
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bus.mem_req[i]) sel = PW'(i);
    end
`endif
    req_pkt = bus.fu_mem_packet[sel];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    off_d   = off_q;
    err_d   = err_q;
    tag_d   = tag_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    bsize_d = bsize_q;
    rdata_d = rdata_q;
`ifdef DMEM_RR_ARB_EN
    rr_d    = rr_q;
`endif
    ack_vec = '0;
    bus_cmd = BUS_NONE;

    case (state_q)
      IDLE: begin
        if (|bus.mem_req) begin
          grant_d = sel;
          cmd_d   = req_pkt.command;
          off_d   = req_pkt.addr[2:0];
          err_d   = misaligned(req_pkt.size, req_pkt.addr[2:0]);
          if (req_pkt.command == FU_LOAD) begin
            baddr_d = {req_pkt.addr[`XLEN-1:3], 3'b000};
            bsize_d = DOUBLE;
            bdata_d = '0;
          end else begin
            baddr_d = req_pkt.addr;
            bsize_d = req_pkt.size;
            bdata_d = store_lane(req_pkt.data, req_pkt.addr[2:0]);
          end
          state_d = err_d ? ACK : SEND;
        end
      end
      SEND: begin
        bus_cmd = (cmd_q == FU_LOAD) ? BUS_LOAD : BUS_STORE;
        // A zero response means the bus rejected us; hold everything and retry.
        if (bus.Mem2proc_response != 4'd0) begin
          if (cmd_q == FU_LOAD) begin
            tag_d   = bus.Mem2proc_response;
            state_d = WAIT;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (bus.Mem2proc_tag != 4'd0 && bus.Mem2proc_tag == tag_q) begin
          rdata_d[grant_q] = load_extract(bus.Mem2proc_data, off_q);
          state_d          = ACK;
        end
      end
      ACK: begin
        ack_vec[grant_q] = 1'b1;
        tag_d            = 4'd0;
        state_d          = IDLE;
`ifdef DMEM_RR_ARB_EN
        rr_d = (grant_q == PW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cmd_q   <= FU_LOAD;
      off_q   <= '0;
      err_q   <= 1'b0;
      tag_q   <= 4'd0;
      baddr_q <= '0;
      bdata_q <= '0;
      bsize_q <= BYTE;
      rdata_q <= '0;
`ifdef DMEM_RR_ARB_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      off_q   <= off_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
      bsize_q <= bsize_d;
      rdata_q <= rdata_d;
`ifdef DMEM_RR_ARB_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign bus.mem_ack           = ack_vec;
  assign bus.mem_err           = err_q ? ack_vec : '0;
  assign bus.Dmem2proc_data    = rdata_q;
  assign bus.proc2Dmem_command = bus_cmd;
  assign bus.proc2Dmem_addr    = baddr_q;
  assign bus.proc2Dmem_data    = bdata_q;
  assign bus.proc2Dmem_size    = bsize_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the functional-unit data-memory handshake. It accepts `mem_req` + `FU_MEM_PACKET` from up to `N_PORTS` requesters (load FU, store FU) and arbitrates them onto the single tagged data-memory bus. It runs each transaction to completion and returns a one-cycle `mem_ack` together with data already shifted to bits [`XLEN-1:0]`. Requesters apply sign/zero extension themselves.

## Interface
- `N_PORTS`, default 2: number of requester ports; port 0 is the load FU.
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `mem_req` input [N_PORTS-1:0]: request per port; held high until that port's ack.
- `fu_mem_packet` input FU_MEM_PACKET [N_PORTS-1:0]: command, addr, data, size; stable while req is high.
- `mem_ack` output [N_PORTS-1:0]: one-cycle completion pulse.
- `mem_err` output [N_PORTS-1:0]: high with `mem_ack` when the access was misaligned.
- `Dmem2proc_data` output [N_PORTS-1:0][`XLEN-1:0]: load data, right-justified; held until that port's next ack.
- `proc2Dmem_command` output BUS_COMMAND: BUS_NONE, BUS_LOAD or BUS_STORE.
- `proc2Dmem_addr` output [`XLEN-1:0]: bus address.
- `proc2Dmem_data` output [63:0]: store data, lane-shifted.
- `proc2Dmem_size` output MEM_SIZE: bus access size.
- `Mem2proc_response` input [3:0]: transaction tag; 0 means rejected.
- `Mem2proc_data` input [63:0]: returned 8-byte block.
- `Mem2proc_tag` input [3:0]: completing tag; 0 means none.

## Operation
- FSM states: IDLE, SEND, WAIT, ACK.
- **IDLE**
  - If any `mem_req` is set, grant one port and latch its packet.
  - Misaligned check: HALF with addr[0]≠0, or WORD with addr[1:0]≠0. A misaligned request goes to ACK with err=1 and no bus traffic.
  - Otherwise go to SEND.
- **SEND**: drive the command.
  - Load: BUS_LOAD, addr = {addr[`XLEN-1:3],3'b0}, size DOUBLE.
  - Store: BUS_STORE, full addr, original size, data = zero-extended store data << (8·addr[2:0]).
  - `Mem2proc_response`==0: stay in SEND and redrive the same values.
  - Nonzero response on a load: latch the tag and go to WAIT.
  - Nonzero response on a store: go to ACK.
  - `Mem2proc_tag` is ignored in SEND.
- **WAIT**: command is BUS_NONE.
  - When `Mem2proc_tag` is nonzero and equals the latched tag, capture `Mem2proc_data >> (8·addr[2:0])`, truncated to `XLEN`, into the granted port's data register.
  - Then go to ACK.
- **ACK**
  - `mem_ack[grant]`=1 for exactly one cycle, with `mem_err` as computed.
  - Clear the latched tag to 0, then go to IDLE.
  - No arbitration occurs in ACK.
- `proc2Dmem_command` is BUS_NONE in every state except SEND.
- The grant is locked from IDLE until ACK. A req change on the granted port mid-transaction is ignored; the transaction completes.
- A req on a non-granted port waits and is not lost.
- Memory responses whose tag does not match are ignored.

## Timing
- Reset values: state IDLE, `mem_ack`/`mem_err` 0, all `Dmem2proc_data` 0, command BUS_NONE, addr/data/size 0, latched tag 0.
- Reset mid-transaction: the FSM returns to IDLE immediately and no ack is issued. Later memory completions for the abandoned tag never match, because the latched tag is 0.
- Let cycle 0 be the IDLE cycle in which req is sampled.
  - Command is driven in cycle 1.
  - Store accepted in cycle 1: ack in cycle 2.
  - Load accepted in cycle 1 with tag match in cycle m: data and ack in cycle m+1.
  - Misaligned: ack in cycle 1.
- Each rejected response adds one cycle.
- The next grant occurs no earlier than the cycle after ACK. A requester clears req on the ack edge, so it is never re-granted spuriously.
- All outputs are registered or decoded from state only; there is no combinational path from memory inputs to `mem_ack`.

## Configuration
- `DMEM_RR_ARB_EN` defined:
  - Round-robin arbitration; the pointer advances to the port after the granted port on each ACK.
  - The pointer resets to port 0.
- Undefined: fixed priority, lowest index wins, so loads beat stores.

## Test plan
- Aligned LW, addr 0x104, with memory returning block 0x1122334455667788 and tag 3 four cycles after accept:
  - Bus shows addr 0x100, size DOUBLE.
  - ack[0] pulses once, with `Dmem2proc_data[0]`=0x11223344, in the cycle after the tag.
- LB at addr 0x107, block 0xAB00000000000000: `Dmem2proc_data[0]`[7:0]=0xAB.
- SH of 0xBEEF at addr 0x206:
  - Bus shows BUS_STORE, addr 0x206, size HALF, data 0xBEEF000000000000.
  - ack[1] two cycles after req.
- SW at addr 0x102: no bus command, ack[1]=1 and err[1]=1 one cycle after req.
- Load and store requested in the same cycle, repeated three times:
  - Without the macro, every load is served first.
  - With `DMEM_RR_ARB_EN`, grants alternate 0,1,0.
- Load with response 0 twice, then tag 5; a foreign tag 2 appears in WAIT; reset is pulsed during a second load's WAIT:
  - The command is redriven twice and tag 2 is ignored.
  - The first load acks only on tag 5.
  - The second load produces no ack, and its later tag 5 completion is ignored.
